// File: rtl/vadd_fp16_seq.sv
// vadd_fp16_seq: sequential FP16 vector adder.
// Two packed vectors of LANES half-precision operands are latched on start.
// One lane per clock is then evaluated through a single shared FP16 add
// datapath, and each result is written into a held result register.
// Optional feature macro: VADD_SUB_EN (adds the sub port; sub = 1 gives A-B).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    request, sampled only in IDLE
//   sub      operation select, latched with start (VADD_SUB_EN only)
//   Inval1   operand A vector, lane k = bits [16k+15:16k]
//   Inval2   operand B vector, same packing
//   SumV     result vector, held until the next start
//   Overflw  sticky OR of per-lane overflow for the current operation
//   busy     high while lanes are being evaluated
//   done     single-cycle pulse once SumV is complete
module vadd_fp16_seq #(
  parameter int LANES = 16,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef VADD_SUB_EN
  input  logic                  sub,
`endif
  input  logic [16*LANES-1:0]   Inval1,
  input  logic [16*LANES-1:0]   Inval2,
  output logic [16*LANES-1:0]   SumV,
  output logic                  Overflw,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  // Single-lane FP16 add. Returns {overflow, result[15:0]}.
  function automatic logic [16:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [14:0] mx;
    logic [14:0] my;
    logic [14:0] acc;
    logic [4:0]  d;
    logic [5:0]  e;
    logic [10:0] man;
    logic [11:0] rnd;
    logic        stk;
    logic [16:0] r;
    r   = 17'd0;
    x   = a;
    y   = b;
    acc = 15'd0;
    e   = 6'd0;
    man = 11'd0;
    rnd = 12'd0;
    stk = 1'b0;
    if (a[14:10] == 5'h1f) begin
      r = {1'b1, a[15], 5'h1f, 10'h000};
    end else if (b[14:10] == 5'h1f) begin
      r = {1'b1, b[15], 5'h1f, 10'h000};
    end else begin
      // x holds the larger magnitude; {exp,frac} compares as magnitude.
      if (a[14:0] >= b[14:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      mx = {1'b0, (x[14:10] != 5'd0), x[9:0], 3'b000};
      my = {1'b0, (y[14:10] != 5'd0), y[9:0], 3'b000};
      d  = x[14:10] - y[14:10];
      // Bits shifted out of the smaller significand collapse into bit 0.
      for (int i = 0; i < 15; i++) begin
        if (5'(i) < d) begin
          stk = stk | my[i];
        end else begin
          stk = stk;
        end
      end
      my = (my >> d) | {14'd0, stk};
      if (x[15] == y[15]) begin
        acc = mx + my;
      end else begin
        acc = mx - my;
      end
      e = {1'b0, x[14:10]};
      if (acc == 15'd0) begin
        r = 17'd0;
      end else begin
        if (acc[14]) begin
          acc = {1'b0, acc[14:2], acc[1] | acc[0]};
          e   = e + 6'd1;
        end else begin
          for (int i = 0; i < 14; i++) begin
            if (!acc[13] && (e != 6'd0)) begin
              acc = acc << 1;
              e   = e - 6'd1;
            end else begin
              acc = acc;
            end
          end
        end
        man = acc[13:3];
        if (acc[2]) begin
          rnd = {1'b0, man} + 12'd1;
          if (rnd[11]) begin
            man = rnd[11:1];
            e   = e + 6'd1;
          end else begin
            man = rnd[10:0];
          end
        end else begin
          man = man;
        end
        if (e >= 6'd31) begin
          r = {1'b1, x[15], 5'h1f, 10'h000};
        end else begin
          r = {1'b0, x[15], e[4:0], man[9:0]};
        end
      end
    end
    return r;
  endfunction

  logic [1:0]            state_r;
  logic [IDXW-1:0]       idx_r;
  logic [16*LANES-1:0]   a_r;
  logic [16*LANES-1:0]   b_r;
  logic [16*LANES-1:0]   sumv_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  sub_r;
  logic [15:0]           a_lane_s;
  logic [15:0]           b_lane_s;
  logic [16:0]           res_s;

  // Select the current lane and evaluate it through the shared adder.
  always_comb begin
    a_lane_s = a_r[{idx_r, 4'b0000} +: 16];
    b_lane_s = b_r[{idx_r, 4'b0000} +: 16];
    b_lane_s[15] = b_lane_s[15] ^ sub_r;
    res_s = fp16_add(a_lane_s, b_lane_s);
  end

  // Control FSM, operand latches and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      sumv_r  <= '0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= Inval1;
            b_r     <= Inval2;
`ifdef VADD_SUB_EN
            sub_r   <= sub;
`else
            sub_r   <= 1'b0;
`endif
            sumv_r  <= '0;
            ovf_r   <= 1'b0;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          sumv_r[{idx_r, 4'b0000} +: 16] <= res_s[15:0];
          ovf_r <= ovf_r | res_s[16];
          if (idx_r == LAST_IDX) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign SumV    = sumv_r;
  assign Overflw = ovf_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
